// File: rtl/alu_pipe_if.sv
// Handshake bundle for alu_pipe: an operation request stream in, a result stream with flags out.
// The WIDTH parameter must match the WIDTH of the alu_pipe instance it is connected to.
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op_code;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic             a_is_zero;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, op_code, in_a, in_b, out_ready,
    input  in_ready, out_valid, alu_out, a_is_zero, carry, overflow
  );

  modport slave (
    input  in_valid, op_code, in_a, in_b, out_ready,
    output in_ready, out_valid, alu_out, a_is_zero, carry, overflow
  );
endinterface

// File: rtl/alu_pipe.sv
// Pipelined flag-producing ALU: compute in stage 1, then STAGES-1 pure delay stages.
// The whole pipe shifts together whenever the output slot is free or being drained.
module alu_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input logic       clk,
  input logic       rst_,
  alu_pipe_if.slave bus
);

  localparam logic [3:0] OpAdd   = 4'd2;
  localparam logic [3:0] OpAnd   = 4'd3;
  localparam logic [3:0] OpXor   = 4'd4;
  localparam logic [3:0] OpPassB = 4'd5;
  localparam logic [3:0] OpSub   = 4'd8;
  localparam logic [3:0] OpAdc   = 4'd9;
  localparam logic [3:0] OpOr    = 4'd10;
  localparam logic [3:0] OpShl   = 4'd11;
  localparam logic [3:0] OpShr   = 4'd12;
  localparam logic [3:0] OpAsr   = 4'd13;
  localparam logic [3:0] OpCmp   = 4'd14;

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             cy;
    logic             ovf;
  } stage_t;

  stage_t         stage_q [STAGES];
  stage_t         stage_d;
  logic           carry_q;
  logic           carry_d;
  logic           advance;
  logic           accept;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign advance = !stage_q[STAGES-1].vld || bus.out_ready;
  assign accept  = bus.in_valid && advance;

  always_comb begin
    sum = {1'b0, bus.in_a} + {1'b0, bus.in_b}
        + {{WIDTH{1'b0}}, (bus.op_code == OpAdc) && carry_q};
    // Top bit of the widened difference is the borrow (a < b unsigned).
    diff = {1'b0, bus.in_a} - {1'b0, bus.in_b};

    stage_d      = '0;
    stage_d.vld  = bus.in_valid;
    stage_d.res  = bus.in_a;
    stage_d.zero = (bus.in_a == '0);
    carry_d      = carry_q;

    case (bus.op_code)
      OpAdd, OpAdc: begin
        stage_d.res = sum[WIDTH-1:0];
        carry_d     = sum[WIDTH];
        stage_d.ovf = (bus.in_a[WIDTH-1] == bus.in_b[WIDTH-1])
                   && (sum[WIDTH-1] != bus.in_a[WIDTH-1]);
      end
      OpAnd:   stage_d.res = bus.in_a & bus.in_b;
      OpXor:   stage_d.res = bus.in_a ^ bus.in_b;
      OpPassB: stage_d.res = bus.in_b;
      OpOr:    stage_d.res = bus.in_a | bus.in_b;
      OpSub, OpCmp: begin
        if (bus.op_code == OpSub) stage_d.res = diff[WIDTH-1:0];
        carry_d     = diff[WIDTH];
        stage_d.ovf = (bus.in_a[WIDTH-1] != bus.in_b[WIDTH-1])
                   && (diff[WIDTH-1] != bus.in_a[WIDTH-1]);
      end
      OpShl: begin
        stage_d.res = {bus.in_a[WIDTH-2:0], 1'b0};
        carry_d     = bus.in_a[WIDTH-1];
        stage_d.ovf = bus.in_a[WIDTH-1] ^ bus.in_a[WIDTH-2];
      end
      OpShr: begin
        stage_d.res = {1'b0, bus.in_a[WIDTH-1:1]};
        carry_d     = bus.in_a[0];
      end
      OpAsr: begin
        stage_d.res = {bus.in_a[WIDTH-1], bus.in_a[WIDTH-1:1]};
        carry_d     = bus.in_a[0];
      end
      default: ;
    endcase

    stage_d.cy = carry_d;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < int'(STAGES); i++) stage_q[i] <= '0;
      carry_q <= 1'b0;
    end else begin
      if (accept) carry_q <= carry_d;
      if (advance) begin
        stage_q[0] <= stage_d;
        for (int i = 1; i < int'(STAGES); i++) stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = stage_q[STAGES-1].vld;
  assign bus.alu_out   = stage_q[STAGES-1].res;
  assign bus.a_is_zero = stage_q[STAGES-1].zero;
  assign bus.carry     = stage_q[STAGES-1].cy;
  assign bus.overflow  = stage_q[STAGES-1].ovf;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed vectors push expected results, a monitor pops on output.
module tb_alu_pipe;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(8))  bus0 ();
  alu_pipe_if #(.WIDTH(16)) bus1 ();
  alu_pipe_if #(.WIDTH(16)) bus4 ();

  alu_pipe #(.WIDTH(8),  .STAGES(2)) dut0 (.clk(clk), .rst_(rst_), .bus(bus0));
  alu_pipe #(.WIDTH(16), .STAGES(1)) dut1 (.clk(clk), .rst_(rst_), .bus(bus1));
  alu_pipe #(.WIDTH(16), .STAGES(4)) dut4 (.clk(clk), .rst_(rst_), .bus(bus4));

  typedef struct {
    logic [7:0] res;
    logic       z;
    logic       c;
    logic       v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   bp_mode = 1'b0;
  int   bp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic        stall_prev = 1'b0;
    logic [10:0] held = '0;
    int          n = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_) begin
        stall_prev = 1'b0;
      end else begin
        chk("in_ready_rule", bus0.in_ready, !(bus0.out_valid && !bus0.out_ready));
        if (stall_prev)
          chk("stall_hold", {bus0.out_valid, bus0.alu_out, bus0.a_is_zero, bus0.carry,
                             bus0.overflow}, {1'b1, held});
        if (bus0.out_valid && bus0.out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_out", bus0.out_valid, 0);
          end else begin
            e = sb.pop_front();
            chk($sformatf("alu_out[%0d]", n), bus0.alu_out, e.res);
            chk($sformatf("a_is_zero[%0d]", n), bus0.a_is_zero, e.z);
            chk($sformatf("carry[%0d]", n), bus0.carry, e.c);
            chk($sformatf("overflow[%0d]", n), bus0.overflow, e.v);
            n++;
          end
        end
        stall_prev = bus0.out_valid && !bus0.out_ready;
        held = {bus0.alu_out, bus0.a_is_zero, bus0.carry, bus0.overflow};
      end
    end
  endtask

  // Downstream backpressure pattern 1,0,0 repeating while enabled.
  task automatic bp_driver();
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        bus0.out_ready = (bp_cnt % 3 == 0);
        bp_cnt++;
      end
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] res, input logic z, input logic c, input logic v,
                       input bit push);
    exp_t e;
    e.res = res; e.z = z; e.c = c; e.v = v;
    bus0.in_valid = 1'b1;
    bus0.op_code  = op;
    bus0.in_a     = a;
    bus0.in_b     = b;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus0.in_ready) begin
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL issue_timeout op=%0h never accepted", op);
    bus0.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && sb.size() != 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  int          lat1, lat4;
  logic [15:0] r1, r4;
  logic        c1, c4, v1, v4;

  initial begin
    bus0.in_valid = 1'b0; bus0.op_code = '0; bus0.in_a = '0; bus0.in_b = '0;
    bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.op_code = '0; bus1.in_a = '0; bus1.in_b = '0;
    bus1.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.op_code = '0; bus4.in_a = '0; bus4.in_b = '0;
    bus4.out_ready = 1'b1;

    fork
      monitor();
      bp_driver();
      begin
        #200000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "watchdog");
      end
    join_none

    #3;
    chk("rst_out_valid", bus0.out_valid, 0);
    chk("rst_alu_out", bus0.alu_out, 0);
    chk("rst_flags", {bus0.a_is_zero, bus0.carry, bus0.overflow}, 0);
    chk("rst_in_ready", bus0.in_ready, 1);
    #9 rst_ = 1'b1;
    @(posedge clk);
    #1;

    // Legacy opcodes back-to-back.
    issue(4'd0, 8'h42, 8'h86, 8'h42, 0, 0, 0, 1);
    issue(4'd1, 8'h42, 8'h86, 8'h42, 0, 0, 0, 1);
    issue(4'd2, 8'h42, 8'h86, 8'hC8, 0, 0, 0, 1);
    issue(4'd3, 8'h42, 8'h86, 8'h02, 0, 0, 0, 1);
    issue(4'd4, 8'h42, 8'h86, 8'hC4, 0, 0, 0, 1);
    issue(4'd5, 8'h42, 8'h86, 8'h86, 0, 0, 0, 1);
    issue(4'd6, 8'h42, 8'h86, 8'h42, 0, 0, 0, 1);
    issue(4'd7, 8'h42, 8'h86, 8'h42, 0, 0, 0, 1);
    issue(4'd7, 8'h00, 8'h86, 8'h00, 1, 0, 0, 1);

    // Carry chain, with and without an intervening AND.
    issue(4'd2, 8'hFF, 8'h01, 8'h00, 0, 1, 0, 1);
    issue(4'd9, 8'h00, 8'h00, 8'h01, 1, 0, 0, 1);
    issue(4'd2, 8'hFF, 8'h01, 8'h00, 0, 1, 0, 1);
    issue(4'd3, 8'h0F, 8'hF0, 8'h00, 0, 1, 0, 1);
    issue(4'd9, 8'h00, 8'h00, 8'h01, 1, 0, 0, 1);

    // Signed arithmetic and shifts.
    issue(4'd2,  8'h7F, 8'h01, 8'h80, 0, 0, 1, 1);
    issue(4'd8,  8'h00, 8'h01, 8'hFF, 1, 1, 0, 1);
    issue(4'd14, 8'h05, 8'h05, 8'h05, 0, 0, 0, 1);
    issue(4'd13, 8'h80, 8'h00, 8'hC0, 0, 0, 0, 1);
    issue(4'd12, 8'h81, 8'h00, 8'h40, 0, 1, 0, 1);
    issue(4'd9,  8'h10, 8'h20, 8'h31, 0, 0, 0, 1);
    issue(4'd11, 8'h40, 8'h00, 8'h80, 0, 0, 1, 1);
    issue(4'd8,  8'h80, 8'h01, 8'h7F, 0, 0, 1, 1);
    issue(4'd10, 8'hA0, 8'h05, 8'hA5, 0, 0, 0, 1);
    issue(4'd15, 8'h3C, 8'hFF, 8'h3C, 0, 0, 0, 1);
    drain();

    // Backpressure stream.
    bp_cnt  = 0;
    bp_mode = 1'b1;
    issue(4'd2, 8'h01, 8'h01, 8'h02, 0, 0, 0, 1);
    issue(4'd2, 8'h10, 8'h20, 8'h30, 0, 0, 0, 1);
    issue(4'd2, 8'hF0, 8'h20, 8'h10, 0, 1, 0, 1);
    issue(4'd2, 8'h40, 8'h40, 8'h80, 0, 0, 1, 1);
    issue(4'd2, 8'h80, 8'h80, 8'h00, 0, 1, 1, 1);
    issue(4'd2, 8'h03, 8'h04, 8'h07, 0, 0, 0, 1);
    drain();
    bp_mode = 1'b0;
    bus0.out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset with two transactions in flight and C=1.
    issue(4'd2, 8'hFF, 8'h01, 8'h00, 0, 1, 0, 0);
    issue(4'd3, 8'h0F, 8'hF0, 8'h00, 0, 1, 0, 0);
    rst_ = 1'b0;
    #1;
    chk("midrst_out_valid", bus0.out_valid, 0);
    chk("midrst_alu_out", bus0.alu_out, 0);
    chk("midrst_flags", {bus0.a_is_zero, bus0.carry, bus0.overflow}, 0);
    chk("midrst_in_ready", bus0.in_ready, 1);
    #1 rst_ = 1'b1;
    @(posedge clk);
    #1;
    issue(4'd9, 8'h00, 8'h00, 8'h00, 1, 0, 0, 1);
    drain();

    // Parameter sweep: latency 1 and 4 at WIDTH=16.
    bus1.in_valid = 1'b1; bus1.op_code = 4'd2; bus1.in_a = 16'hFFFF; bus1.in_b = 16'h0001;
    bus4.in_valid = 1'b1; bus4.op_code = 4'd2; bus4.in_a = 16'hFFFF; bus4.in_b = 16'h0001;
    @(negedge clk);
    chk("sw1_in_ready", bus1.in_ready, 1);
    chk("sw4_in_ready", bus4.in_ready, 1);
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    bus4.in_valid = 1'b0;
    lat1 = 0; lat4 = 0;
    r1 = '1; r4 = '1; c1 = 1'b0; c4 = 1'b0; v1 = 1'b1; v4 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if (lat1 == 0 && bus1.out_valid) begin
        lat1 = k; r1 = bus1.alu_out; c1 = bus1.carry; v1 = bus1.overflow;
      end
      if (lat4 == 0 && bus4.out_valid) begin
        lat4 = k; r4 = bus4.alu_out; c4 = bus4.carry; v4 = bus4.overflow;
      end
      @(posedge clk);
      #1;
    end
    chk("sw1_latency", lat1, 1);
    chk("sw4_latency", lat4, 4);
    chk("sw1_alu_out", r1, 16'h0000);
    chk("sw4_alu_out", r4, 16'h0000);
    chk("sw1_carry", c1, 1);
    chk("sw4_carry", c4, 1);
    chk("sw1_overflow", v1, 0);
    chk("sw4_overflow", v4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Pipelined, flag-producing successor to the VeriRISC combinational ALU. Accepts one operation per cycle over a valid/ready handshake, carries results through a parametrised number of register stages, and returns result plus zero/carry/overflow flags. Opcodes 0-7 keep the existing ALU semantics bit-for-bit. Opcodes 8-15 add subtract, add-with-carry, OR, shifts and compare. It sits between the controller/decoder and the accumulator write-back path.

## Interface
- WIDTH, 8, datapath width in bits (>= 2)
- STAGES, 2, pipeline depth = input-to-output latency in cycles (1..4)

- clk  in  1  rising-edge clock
- rst_  in  1  asynchronous, active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  pipeline can accept this cycle
- op_code  in  4  operation select
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- out_valid  out  1  result present at pipeline output
- out_ready  in  1  downstream accepts result
- alu_out  out  WIDTH  result
- a_is_zero  out  1  in_a of this transaction was all zeros
- carry  out  1  carry flag after this transaction
- overflow  out  1  signed overflow of this transaction

## Operation
- Opcodes:
  - 0, 1, 6, 7, 15: PASS A.
  - 2 ADD: a+b.
  - 3 AND.
  - 4 XOR.
  - 5 PASS B.
  - 8 SUB: a-b.
  - 9 ADC: a+b+C.
  - 10 OR.
  - 11 SHL1: a<<1, LSB 0.
  - 12 SHR1: logical, MSB 0.
  - 13 ASR1: MSB replicated.
  - 14 CMP: alu_out = a; flags as SUB.
- Internal carry flag C, updated at accept time (in_valid && in_ready), in issue order. ADC therefore uses the carry of the immediately preceding accepted transaction.
- C update rules:
  - ADD/ADC: bit WIDTH of the WIDTH+1-bit sum.
  - SUB/CMP: borrow, i.e. 1 iff a < b unsigned.
  - SHL1: a[WIDTH-1].
  - SHR1/ASR1: a[0].
  - All other ops: C unchanged.
- The carry output equals the value of C after the update made by that transaction.
- overflow rules:
  - ADD/ADC: operands of equal sign and result sign different.
  - SUB/CMP: operand signs differ and result sign differs from a.
  - SHL1: a[WIDTH-1] ^ a[WIDTH-2].
  - All other ops: 0.
- Arithmetic is modulo 2^WIDTH; alu_out is truncated to WIDTH bits.
- a_is_zero is computed from in_a at accept time (including for PASS B and CMP) and travels with the result.
- Computation happens in stage 1; the remaining STAGES-1 stages are pure delay registers holding {valid, alu_out, flags}.

## Timing
- advance = !out_valid || out_ready.
- in_ready = advance (combinational). The whole pipeline shifts one stage on advance and holds otherwise; internal bubbles collapse only when advancing.
- A transaction accepted at edge N appears at the output (out_valid=1) after edge N+STAGES-1 if unstalled, i.e. latency STAGES.
- Throughput is 1 per cycle while out_ready=1.
- Output stability: while out_valid && !out_ready, alu_out/a_is_zero/carry/overflow hold stable. No new accept occurs and C does not change.
- in_valid=0 on an advancing cycle inserts a bubble: valid=0 into stage 1, C unchanged.
- Simultaneous output drain and input accept in the same cycle is legal and required for full throughput.
- Reset (asynchronous, any time, including mid-stream or mid-stall):
  - All stage valids cleared; in-flight transactions discarded.
  - out_valid=0, alu_out=0, a_is_zero=0, carry=0, overflow=0.
  - C=0.
  - in_ready=1 while rst_ is high and the pipeline is empty.
- Outputs are registered; only in_ready is combinational (from out_valid, out_ready).

## Test plan
- Legacy ops, WIDTH=8, STAGES=2, out_ready=1, a=0x42, b=0x86 on ops 0-7 back-to-back:
  - Outputs 2 cycles after each accept: 42,42,C8,02,C4,86,42,42.
  - a_is_zero=0 throughout.
  - Then op 7 with a=0x00 -> alu_out=00, a_is_zero=1.
- Carry chain:
  - ADD FF+01 -> alu_out=00, carry=1, overflow=0.
  - Next ADC 00+00 -> alu_out=01, carry=0.
  - AND between the two must not disturb C: ADC still yields 01.
- Signed/shift:
  - ADD 7F+01 -> 80, overflow=1.
  - SUB 00-01 -> FF, carry=1.
  - CMP 05 vs 05 -> alu_out=05, carry=0, overflow=0.
  - ASR1 80 -> C0, carry=0.
  - SHR1 81 -> 40, carry=1.
  - SHL1 40 -> 80, overflow=1.
- Backpressure: stream 6 ADDs with out_ready toggling 1,0,0,1,...
  - No result lost or duplicated; outputs stable while stalled.
  - in_ready=0 exactly when out_valid && !out_ready.
  - Order preserved.
- Reset mid-stream: assert rst_ low asynchronously with 2 transactions in flight and C=1.
  - Immediately out_valid=0 and all outputs 0.
  - After release, ADC 00+00 -> 00, showing C was cleared.
- Parameter sweep: STAGES=1 and 4, WIDTH=16.
  - Latency equals STAGES.
  - ADD FFFF+0001 -> 0000, carry=1.
